d_reg_universal_ce_sclr: RTL
============================

Name: d_reg_universal_ce_sclr

Overview:
- Parametrised successor to the single-bit D flip-flop with clock enable and synchronous reset.
- WIDTH-bit register with:
  - clock enable;
  - synchronous clear;
  - asynchronous active-low reset;
  - mode-selected next-state function: hold, load, shift, rotate, arithmetic shift, increment.
- Serves as the general storage/shift/count element for later labs: serialisers, LFSR seeds, counters.

Parameters:
- WIDTH, 8: register width in bits. Legal range is WIDTH >= 2; elaboration fails otherwise.
- RESET_VAL, {WIDTH{1'b0}}: value of Q after async reset or sync clear.

Ports:
- Clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- ce  input  1  clock enable; gates mode operations only.
- sclr  input  1  synchronous clear; active-high; independent of ce.
- mode  input  3  operation select (encodings under Behaviour).
- D  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering bit 0 on SHL.
- sin_l  input  1  serial input entering bit WIDTH-1 on SHR.
- Q  output  WIDTH  register contents.
- cout  output  1  registered shifted-out bit, rotated bit, or increment carry.
- sout_l  output  1  Q[WIDTH-1], combinational from Q.
- sout_r  output  1  Q[0], combinational from Q.
- zero  output  1  (Q == 0), combinational from Q.

Behaviour:
- Priority per rising edge:
  1. reset_n low: asynchronous; overrides everything.
  2. sclr high.
  3. ce low.
  4. mode operation.
- Reset values (reset_n low): Q = RESET_VAL, cout = 0, asserted immediately without waiting for Clk. Release is synchronous in effect: the first edge with reset_n high applies the normal rules.
- sclr = 1 at an edge: Q <= RESET_VAL, cout <= 0, whatever ce and mode are.
- ce = 0 (and sclr = 0): Q and cout hold; mode, D and serial inputs are ignored.
- ce = 1, sclr = 0, mode encodings:
  - 000 HOLD: Q and cout unchanged.
  - 001 LOAD: Q <= D; cout <= 0.
  - 010 SHL: Q <= {Q[W-2:0], sin_r}; cout <= Q[W-1].
  - 011 SHR: Q <= {sin_l, Q[W-1:1]}; cout <= Q[0].
  - 100 ROL: Q <= {Q[W-2:0], Q[W-1]}; cout <= Q[W-1].
  - 101 ROR: Q <= {Q[0], Q[W-1:1]}; cout <= Q[0].
  - 110 ASR: Q <= {Q[W-1], Q[W-1:1]}; cout <= Q[0]. Sign bit is replicated.
  - 111 INC: Q <= Q + 1 modulo 2^WIDTH; cout <= 1 only when Q was all-ones (the wrap), else 0.
- Latency: one Clk edge from input to Q/cout. sout_l, sout_r and zero follow Q with no added latency.
- Timing of inputs: all inputs other than reset_n are sampled only at the rising Clk edge; changes between edges have no effect.
- Boundary conditions:
  - INC at all-ones: Q becomes 0, zero asserts, cout = 1 for exactly that cycle unless a later op changes it.
  - ce toggling mid-sequence freezes the shift position exactly.
  - reset_n asserted mid-operation aborts that operation. Q = RESET_VAL persists until the first enabled edge after release.
  - sclr and ce both high: clear wins.
  - RESET_VAL nonzero: zero is deasserted after reset.

Decomposition:
- Shared package holds:
  - the 3-bit mode localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_INC;
  - the mode width constant.
- Submodule reg_next_state_logic (combinational): computes {cout_next, Q_next} from Q, mode, D, sin_l and sin_r.
- The top-level block holds only the flops, priority logic and output assigns.
- Bench drives Clk with a 20 ns period (toggle every 10 ns), consistent with existing lab benches.

Test Plan:
- Reset: hold reset_n=0 with D=8'hFF, mode=LOAD, ce=1 -> Q=8'h00, cout=0, zero=1. Release, next edge -> Q=8'hFF.
- ce gating: Q=8'h5A, ce=0, mode=SHL for 3 edges -> Q stays 8'h5A. Set ce=1 for 1 edge with sin_r=1 -> Q=8'hB5, cout=0.
- Shift/rotate: Q=8'h81; ROL -> Q=8'h03, cout=1. ROR -> Q=8'h81, cout=1. Q=8'h80; ASR -> Q=8'hC0, cout=0. SHR with sin_l=0 -> Q=8'h60.
- Increment wrap: LOAD 8'hFE, then INC twice -> Q=8'hFF, cout=0, then Q=8'h00, cout=1, zero=1.
- sync clear priority: Q=8'h3C, sclr=1, ce=0, mode=LOAD, D=8'hAA -> Q=8'h00 after the edge. Same stimulus with sclr=1 and ce=1 -> Q=8'h00.
- Async reset mid-shift: during SHL sequence, pulse reset_n low 3 ns between edges -> Q=8'h00 immediately, not at the next edge. Shifting resumes from 8'h00 after release.

Source files
------------

// File: rtl/d_reg_universal_ce_sclr_pkg.sv
// -----------------------------------------------------------------------------
// d_reg_universal_ce_sclr_pkg
//
// Purpose:
//   Constants shared by the universal register, its bus interface, its
//   next-state logic and its testbench. Holds the operation-select width,
//   the mode type and the eight mode encodings.
//
// Contents:
//   MODE_W      width of the mode select field
//   mode_t      operation-select type
//   MODE_*      operation encodings (HOLD, LOAD, SHL, SHR, ROL, ROR, ASR, INC)
// -----------------------------------------------------------------------------
package d_reg_universal_ce_sclr_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;  // keep Q and cout
    localparam mode_t MODE_LOAD = 3'b001;  // parallel load from D
    localparam mode_t MODE_SHL  = 3'b010;  // shift left, sin_r enters bit 0
    localparam mode_t MODE_SHR  = 3'b011;  // shift right, sin_l enters MSB
    localparam mode_t MODE_ROL  = 3'b100;  // rotate left
    localparam mode_t MODE_ROR  = 3'b101;  // rotate right
    localparam mode_t MODE_ASR  = 3'b110;  // arithmetic shift right
    localparam mode_t MODE_INC  = 3'b111;  // increment modulo 2^WIDTH

endpackage : d_reg_universal_ce_sclr_pkg

// File: rtl/d_reg_universal_ce_sclr_if.sv
// -----------------------------------------------------------------------------
// d_reg_universal_ce_sclr_if
//
// Purpose:
//   Groups the control, data and status signals of the universal register so
//   that producers and the register itself connect through one port.
//
// Parameters:
//   WIDTH   register width; must match the WIDTH of the attached register
//
// Signals:
//   ce      clock enable (gates mode operations only)
//   sclr    synchronous clear, active high
//   mode    operation select (mode_t)
//   D       parallel load data
//   sin_r   serial input entering bit 0 on SHL
//   sin_l   serial input entering bit WIDTH-1 on SHR
//   Q       register contents
//   cout    registered shifted-out / rotated bit or increment carry
//   sout_l  Q[WIDTH-1]
//   sout_r  Q[0]
//   zero    Q == 0
//
// Modports:
//   master  drives the controls and data, observes the status
//   slave   the register: consumes controls and data, drives the status
// -----------------------------------------------------------------------------
interface d_reg_universal_ce_sclr_if #(
    parameter int WIDTH = 8
);
    import d_reg_universal_ce_sclr_pkg::*;

    logic             ce;
    logic             sclr;
    mode_t            mode;
    logic [WIDTH-1:0] D;
    logic             sin_r;
    logic             sin_l;

    logic [WIDTH-1:0] Q;
    logic             cout;
    logic             sout_l;
    logic             sout_r;
    logic             zero;

    modport master (
        output ce, sclr, mode, D, sin_r, sin_l,
        input  Q, cout, sout_l, sout_r, zero
    );

    modport slave (
        input  ce, sclr, mode, D, sin_r, sin_l,
        output Q, cout, sout_l, sout_r, zero
    );

endinterface : d_reg_universal_ce_sclr_if

// File: rtl/reg_next_state_logic.sv
// -----------------------------------------------------------------------------
// reg_next_state_logic
//
// Purpose:
//   Purely combinational next-state function of the universal register.
//   Given the present contents and the selected mode it produces the value
//   Q and cout would take on an enabled, non-cleared clock edge. Clear,
//   enable and reset priority live in the register, not here.
//
// Parameters:
//   WIDTH      register width (>= 2)
//
// Ports:
//   q          present register contents
//   cout       present carry/shift-out bit (kept on HOLD)
//   mode       operation select
//   d          parallel load data
//   sin_l      serial input for SHR (enters MSB)
//   sin_r      serial input for SHL (enters LSB)
//   q_next     next register contents
//   cout_next  next carry/shift-out bit
// -----------------------------------------------------------------------------
module reg_next_state_logic
    import d_reg_universal_ce_sclr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             cout,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_next,
    output logic             cout_next
);

    // One bit wider than Q so the wrap from all-ones shows up as the carry.
    logic [WIDTH:0] inc_sum;

    assign inc_sum = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; a missing
        // assignment on some path would otherwise infer a latch.
        q_next    = q;
        cout_next = cout;

        case (mode)
            MODE_HOLD: begin
                q_next    = q;
                cout_next = cout;
            end
            MODE_LOAD: begin
                q_next    = d;
                cout_next = 1'b0;
            end
            MODE_SHL: begin
                q_next    = {q[WIDTH-2:0], sin_r};
                cout_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next    = {sin_l, q[WIDTH-1:1]};
                cout_next = q[0];
            end
            MODE_ROL: begin
                q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                cout_next = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next    = {q[0], q[WIDTH-1:1]};
                cout_next = q[0];
            end
            MODE_ASR: begin
                // Sign bit is replicated into the vacated MSB.
                q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
                cout_next = q[0];
            end
            MODE_INC: begin
                q_next    = inc_sum[WIDTH-1:0];
                cout_next = inc_sum[WIDTH];
            end
            default: begin
                q_next    = q;
                cout_next = cout;
            end
        endcase
    end

endmodule : reg_next_state_logic

// File: rtl/d_reg_universal_ce_sclr.sv
// -----------------------------------------------------------------------------
// d_reg_universal_ce_sclr
//
// Purpose:
//   WIDTH-bit universal register: hold, load, shift, rotate, arithmetic
//   shift and increment, with clock enable, synchronous clear and
//   asynchronous active-low reset. General storage / shift / count element
//   for serialisers, LFSR seeds and counters.
//
// Parameters:
//   WIDTH      register width, must be >= 2
//   RESET_VAL  value of Q after async reset or synchronous clear
//
// Ports:
//   Clk        rising-edge clock
//   reset_n    asynchronous active-low reset (Q = RESET_VAL, cout = 0)
//   bus        slave side of d_reg_universal_ce_sclr_if:
//                inputs  ce, sclr, mode, D, sin_r, sin_l
//                outputs Q, cout (registered), sout_l, sout_r, zero
//                        (combinational from Q)
//
// Edge priority: reset_n low > sclr high > ce low (hold) > mode operation.
// -----------------------------------------------------------------------------
module d_reg_universal_ce_sclr
    import d_reg_universal_ce_sclr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input logic                      Clk,
    input logic                      reset_n,
    d_reg_universal_ce_sclr_if.slave bus
);

    if (WIDTH < 2) begin : g_width_check
        $error("d_reg_universal_ce_sclr: WIDTH must be >= 2");
    end

    logic [WIDTH-1:0] q_r;
    logic             cout_r;
    logic [WIDTH-1:0] q_next;
    logic             cout_next;

    reg_next_state_logic #(
        .WIDTH (WIDTH)
    ) u_next_state (
        .q         (q_r),
        .cout      (cout_r),
        .mode      (bus.mode),
        .d         (bus.D),
        .sin_l     (bus.sin_l),
        .sin_r     (bus.sin_r),
        .q_next    (q_next),
        .cout_next (cout_next)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r    <= RESET_VAL;
            cout_r <= 1'b0;
        end else if (bus.sclr) begin
            // Clear wins regardless of ce and mode.
            q_r    <= RESET_VAL;
            cout_r <= 1'b0;
        end else if (bus.ce) begin
            q_r    <= q_next;
            cout_r <= cout_next;
        end
    end

    assign bus.Q      = q_r;
    assign bus.cout   = cout_r;
    assign bus.sout_l = q_r[WIDTH-1];
    assign bus.sout_r = q_r[0];
    assign bus.zero   = (q_r == '0);

endmodule : d_reg_universal_ce_sclr
